// File: rtl/mmu_tag_lookup_pkg.sv
// Shared definitions for the MMU tag lookup: widths, address bit positions and FSM state encodings.
// Tag sits at the top of the virtual address; the index bits sit immediately below it.
package mmu_tag_lookup_pkg;

  localparam int unsigned VADR_W    = 32;
  localparam int unsigned TAG_W     = 12;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned N_ENTRIES = 4;

  // Tag occupies VADR[TAG_MSB -: tag_w]
  localparam int unsigned TAG_MSB = VADR_W - 1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOOKUP = 3'd1;
  localparam state_t S_WALK   = 3'd2;
  localparam state_t S_FILL   = 3'd3;
  localparam state_t S_RESP   = 3'd4;

  // Most significant index bit: the bit just below the tag field.
  function automatic int unsigned idx_msb(input int unsigned tag_w);
    return TAG_MSB - tag_w;
  endfunction

endpackage

// File: rtl/mmu_tag_ram.sv
// Tag/data storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module mmu_tag_ram #(
  parameter int unsigned DEPTH  = mmu_tag_lookup_pkg::N_ENTRIES,
  parameter int unsigned WIDTH  = mmu_tag_lookup_pkg::TAG_W + mmu_tag_lookup_pkg::DATA_W,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmu_tag_lookup.sv
// Direct-mapped virtual-tag lookup: hits answer from the tag RAM, misses go out as a table walk
// and successful walks are written back into the indexed entry.
module mmu_tag_lookup #(
  parameter int unsigned N_ENTRIES = mmu_tag_lookup_pkg::N_ENTRIES,
  parameter int unsigned TAG_W     = mmu_tag_lookup_pkg::TAG_W,
  parameter int unsigned DATA_W    = mmu_tag_lookup_pkg::DATA_W
) (
  input  logic              BCLK,
  input  logic              BRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vadr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              walk_req,
  output logic [31:0]       walk_vadr,
  input  logic              walk_done,
  input  logic              walk_fault,
  input  logic [DATA_W-1:0] walk_data,
  input  logic              flush
);

  import mmu_tag_lookup_pkg::*;

  localparam int unsigned IDX_W   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int unsigned IDX_MSB = idx_msb(TAG_W);
  localparam int unsigned ENTRY_W = TAG_W + DATA_W;

  state_t                state_q, state_d;
  logic [31:0]           vadr_q;
  logic [N_ENTRIES-1:0]  valid_q, valid_d;
  logic                  lookup_phase_q;
  logic                  hit_q;
  logic [DATA_W-1:0]     hit_data_q;
  logic [DATA_W-1:0]     fill_data_q;
  logic [DATA_W-1:0]     resp_data_q;
  logic                  resp_fault_q;
  logic [31:0]           walk_vadr_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [ENTRY_W-1:0]    rd_entry;
  logic                  lookup_hit;
  logic                  ram_we;

  assign idx = vadr_q[IDX_MSB -: IDX_W];
  assign tag = vadr_q[TAG_MSB -: TAG_W];

  assign ram_we = (state_q == S_FILL);

  mmu_tag_ram #(
    .DEPTH  (N_ENTRIES),
    .WIDTH  (ENTRY_W),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (BCLK),
    .we    (ram_we),
    .waddr (idx),
    .wdata ({tag, fill_data_q}),
    .raddr (idx),
    .rdata (rd_entry)
  );

  assign lookup_hit = valid_q[idx] && (rd_entry[ENTRY_W-1 -: TAG_W] == tag);

  // Flush takes priority over a coincident fill, so the filled entry ends up invalid.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (ram_we) begin
      valid_d[idx] = 1'b1;
    end
  end

  // LOOKUP spans two cycles: the first snapshots the indexed entry, the second acts on it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: if (lookup_phase_q) state_d = hit_q ? S_RESP : S_WALK;
      S_WALK:   if (walk_done) state_d = walk_fault ? S_RESP : S_FILL;
      S_FILL:   state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge BCLK or negedge BRESET) begin
    if (!BRESET) begin
      state_q        <= S_IDLE;
      valid_q        <= '0;
      vadr_q         <= '0;
      lookup_phase_q <= 1'b0;
      hit_q          <= 1'b0;
      hit_data_q     <= '0;
      fill_data_q    <= '0;
      resp_data_q    <= '0;
      resp_fault_q   <= 1'b0;
      walk_vadr_q    <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      lookup_phase_q <= (state_q == S_LOOKUP) && !lookup_phase_q;

      if (state_q == S_IDLE && req_valid) begin
        vadr_q <= req_vadr;
      end

      if (state_q == S_LOOKUP && !lookup_phase_q) begin
        hit_q      <= lookup_hit;
        hit_data_q <= rd_entry[DATA_W-1:0];
      end

      if (state_q == S_LOOKUP && lookup_phase_q) begin
        if (hit_q) begin
          resp_data_q  <= hit_data_q;
          resp_fault_q <= 1'b0;
        end else begin
          walk_vadr_q <= vadr_q;
        end
      end

      if (state_q == S_WALK && walk_done) begin
        if (walk_fault) begin
          resp_fault_q <= 1'b1;
        end else begin
          fill_data_q <= walk_data;
        end
      end

      if (state_q == S_FILL) begin
        resp_data_q  <= fill_data_q;
        resp_fault_q <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign walk_req   = (state_q == S_WALK);
  assign walk_vadr  = walk_vadr_q;

endmodule

// File: tb/tb_mmu_tag_lookup.sv
// Self-checking bench: a transaction-level model of the direct-mapped table predicts every
// cycle's handshake outputs, which one per-cycle compare step checks against the DUT.
module tb_mmu_tag_lookup;

  logic        BCLK;
  logic        BRESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vadr;
  logic        resp_valid;
  logic        resp_ready;
  logic [23:0] resp_data;
  logic        resp_fault;
  logic        walk_req;
  logic [31:0] walk_vadr;
  logic        walk_done;
  logic        walk_fault;
  logic [23:0] walk_data;
  logic        flush;

  mmu_tag_lookup dut (
    .BCLK       (BCLK),
    .BRESET     (BRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vadr   (req_vadr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .walk_req   (walk_req),
    .walk_vadr  (walk_vadr),
    .walk_done  (walk_done),
    .walk_fault (walk_fault),
    .walk_data  (walk_data),
    .flush      (flush)
  );

  initial BCLK = 1'b0;
  always #5 BCLK = ~BCLK;

  int checks = 0;
  int errors = 0;

  // Behavioural table model, indexed by VADR[19:18].
  bit          m_valid [4];
  logic [11:0] m_tag   [4];
  logic [23:0] m_data  [4];

  // What the outputs must be after the next rising edge.
  bit          chk_en;
  logic        exp_req_ready, exp_resp_valid, exp_walk_req, exp_fault;
  logic [31:0] exp_walk_vadr;
  logic [23:0] exp_data;

  int          walk_cnt = 0;
  int          resp_cnt = 0;
  logic [23:0] last_data;
  logic        last_fault;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void set_exp(input logic rr, input logic rv, input logic wr);
    exp_req_ready  = rr;
    exp_resp_valid = rv;
    exp_walk_req   = wr;
  endfunction

  // One clock: compare just after the rising edge, return on the falling edge.
  task automatic tick();
    @(posedge BCLK);
    #1;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
      chk("walk_req", 32'(walk_req), 32'(exp_walk_req));
      if (exp_walk_req) chk("walk_vadr", walk_vadr, exp_walk_vadr);
      if (exp_resp_valid) chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
      if (exp_resp_valid && !exp_fault) chk("resp_data", 32'(resp_data), 32'(exp_data));
    end
    if (walk_req) walk_cnt++;
    if (resp_valid) begin
      resp_cnt++;
      last_data  = resp_data;
      last_fault = resp_fault;
    end
    @(negedge BCLK);
  endtask

  // Full request/response transaction; called and returns just after a falling edge in IDLE.
  // flush_lk: 0 none, 1/2 = flush during first/second LOOKUP cycle.
  task automatic xact(input logic [31:0] v, input int wdelay, input bit wfault,
                      input logic [23:0] wdata, input int hold, input bit flush_fill,
                      input int flush_lk, output bit was_hit);
    int          idx;
    logic [11:0] tg;
    bit          hit;
    idx = int'(v[19:18]);
    tg  = v[31:20];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    was_hit = hit;

    req_valid = 1'b1;
    req_vadr  = v;
    set_exp(1'b0, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    req_vadr  = $urandom;
    if (flush_lk == 1) begin flush = 1'b1; clear_model(); end
    tick();
    flush = 1'b0;
    if (flush_lk == 2) begin flush = 1'b1; clear_model(); end
    if (hit) begin
      exp_resp_valid = 1'b1;
      exp_fault      = 1'b0;
      exp_data       = m_data[idx];
    end else begin
      exp_walk_req  = 1'b1;
      exp_walk_vadr = v;
    end
    tick();
    flush = 1'b0;
    if (!hit) begin
      repeat (wdelay) tick();
      walk_done    = 1'b1;
      walk_fault   = wfault;
      walk_data    = wdata;
      exp_walk_req = 1'b0;
      if (wfault) begin
        exp_resp_valid = 1'b1;
        exp_fault      = 1'b1;
      end
      tick();
      walk_done  = 1'b0;
      walk_fault = 1'b0;
      walk_data  = $urandom;
      if (!wfault) begin
        flush          = flush_fill;
        exp_resp_valid = 1'b1;
        exp_fault      = 1'b0;
        exp_data       = wdata;
        if (flush_fill) clear_model();
        else begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = tg;
          m_data[idx]  = wdata;
        end
        tick();
        flush = 1'b0;
      end
    end
    // Stray walk_done strobes while responding must be ignored.
    repeat (hold) begin
      walk_done  = ($urandom_range(0, 3) == 0);
      walk_fault = 1'($urandom_range(0, 1));
      walk_data  = $urandom;
      tick();
    end
    walk_done      = 1'b0;
    walk_fault     = 1'b0;
    resp_ready     = 1'b1;
    exp_resp_valid = 1'b0;
    exp_req_ready  = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    clear_model();
    tick();
    flush = 1'b0;
  endtask

  int          c0;
  int          r0;
  bit          h;
  logic [31:0] v;
  logic [11:0] rtag;

  initial begin
    BRESET = 1'b0; req_valid = 1'b0; req_vadr = '0; resp_ready = 1'b0;
    walk_done = 1'b0; walk_fault = 1'b0; walk_data = '0; flush = 1'b0;
    chk_en = 1'b0;
    exp_walk_vadr = '0; exp_data = '0; exp_fault = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    clear_model();
    repeat (2) @(negedge BCLK);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_walk_req", 32'(walk_req), 32'd0);
    chk("rst_walk_vadr", walk_vadr, 32'd0);

    BRESET = 1'b1;
    chk_en = 1'b1;
    tick();

    // Fill, then hit on the same address with 2-cycle latency and no walk.
    c0 = walk_cnt;
    xact(32'h1234_0000, 1, 1'b0, 24'h123456, 0, 1'b0, 0, h);
    chk("first_miss_model", 32'(h), 32'd0);
    chk("first_miss_walked", 32'(walk_cnt - c0), 32'd2);
    c0 = walk_cnt;
    xact(32'h1234_0000, 0, 1'b0, 24'h0, 0, 1'b0, 0, h);
    chk("hit_model", 32'(h), 32'd1);
    chk("hit_no_walk", 32'(walk_cnt - c0), 32'd0);
    chk("hit_data", 32'(last_data), 32'h123456);

    // Miss to index 1 with a 3-cycle walk; overwrites the 0x123 entry.
    c0 = walk_cnt;
    xact(32'hABC4_0000, 2, 1'b0, 24'h5A5A5A, 0, 1'b0, 0, h);
    chk("abc_walk_cycles", 32'(walk_cnt - c0), 32'd3);
    chk("abc_data", 32'(last_data), 32'h5A5A5A);
    c0 = walk_cnt;
    xact(32'hABC4_0000, 0, 1'b0, 24'h0, 0, 1'b0, 0, h);
    chk("abc_rehit", 32'(walk_cnt - c0), 32'd0);
    c0 = walk_cnt;
    xact(32'h1234_0000, 0, 1'b0, 24'h654321, 0, 1'b0, 0, h);
    chk("overwritten_miss", 32'(walk_cnt - c0), 32'd1);

    // Faulting walk leaves the table untouched.
    xact(32'h5558_0000, 1, 1'b1, 24'hDEAD00, 0, 1'b0, 0, h);
    chk("fault_flag", 32'(last_fault), 32'd1);
    c0 = walk_cnt;
    xact(32'h5558_0000, 0, 1'b0, 24'h0F0F0F, 0, 1'b0, 0, h);
    chk("fault_remiss", 32'(walk_cnt - c0), 32'd1);
    chk("fault_refill_flag", 32'(last_fault), 32'd0);

    // Back-pressure for 5 cycles on a hit.
    xact(32'h5558_0000, 0, 1'b0, 24'h0, 5, 1'b0, 0, h);
    chk("hold_data", 32'(last_data), 32'h0F0F0F);

    // Flush coincident with FILL: response still delivered, entry invalid.
    xact(32'h7770_0000, 1, 1'b0, 24'h777777, 0, 1'b1, 0, h);
    chk("flushfill_data", 32'(last_data), 32'h777777);
    c0 = walk_cnt;
    xact(32'h7770_0000, 0, 1'b0, 24'h777778, 0, 1'b0, 0, h);
    chk("flushfill_remiss", 32'(walk_cnt - c0), 32'd1);

    // Flush during LOOKUP does not change the hit decision.
    c0 = walk_cnt;
    xact(32'h7770_0000, 0, 1'b0, 24'h0, 0, 1'b0, 1, h);
    chk("lk_flush_hit", 32'(walk_cnt - c0), 32'd0);

    // All entries valid, then idle flush: every index misses.
    for (int i = 0; i < 4; i++)
      xact(32'h1110_0000 | (32'(i) << 18), 0, 1'b0, 24'(32'h100 + i), 0, 1'b0, 0, h);
    idle_flush();
    for (int i = 0; i < 4; i++) begin
      c0 = walk_cnt;
      xact(32'h1110_0000 | (32'(i) << 18), 0, 1'b0, 24'(32'h200 + i), 0, 1'b0, 0, h);
      chk("postflush_miss", 32'(walk_cnt - c0), 32'd1);
    end

    // Reset in mid-WALK: walk_req drops at once, no response, table empty afterwards.
    for (int i = 0; i < 4; i++)
      xact(32'h2220_0000 | (32'(i) << 18), 0, 1'b0, 24'(32'h300 + i), 0, 1'b0, 0, h);
    r0 = resp_cnt;
    req_valid = 1'b1;
    req_vadr  = 32'h3330_0000;
    set_exp(1'b0, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    exp_walk_req  = 1'b1;
    exp_walk_vadr = 32'h3330_0000;
    tick();
    tick();
    #2;
    BRESET = 1'b0;
    #1;
    chk("rstwalk_walk_req", 32'(walk_req), 32'd0);
    chk("rstwalk_walk_vadr", walk_vadr, 32'd0);
    chk("rstwalk_resp_valid", 32'(resp_valid), 32'd0);
    set_exp(1'b1, 1'b0, 1'b0);
    clear_model();
    tick();
    tick();
    BRESET     = 1'b1;
    walk_done  = 1'b1;
    walk_data  = 24'hBADBAD;
    tick();
    walk_done = 1'b0;
    tick();
    chk("rstwalk_no_resp", 32'(resp_cnt - r0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      c0 = walk_cnt;
      xact(32'h2220_0000 | (32'(i) << 18), 0, 1'b0, 24'(32'h400 + i), 0, 1'b0, 0, h);
      chk("postreset_miss", 32'(walk_cnt - c0), 32'd1);
    end

    // Randomized traffic over a small tag set so hits, misses and overwrites all occur.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: rtag = 12'h123;
        1: rtag = 12'hABC;
        2: rtag = 12'h555;
        default: rtag = 12'($urandom);
      endcase
      v = {rtag, 2'($urandom_range(0, 3)), 18'($urandom)};
      xact(v, $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 24'($urandom),
           $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0, h);
      if ($urandom_range(0, 19) == 0) idle_flush();
      if ($urandom_range(0, 9) == 0) begin
        walk_done  = 1'b1;
        walk_fault = 1'($urandom_range(0, 1));
        walk_data  = $urandom;
        tick();
        walk_done = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
